// File: rtl/calc_alu_seq.sv
// rtl/calc_alu_seq.sv - sequential calculator ALU: single-cycle add/sub/mult, iterative restoring divide
// Optional build macro CALC_ALU_SAT_EN: saturate add/mult to all-ones and clamp sub to 0 on overflow.
module calc_alu_seq #(
    parameter int WIDTH   = 14,
    parameter int ERR_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             ovf,
    output logic             err
);

    typedef enum logic {IDLE, DIV} state_t;

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ERR_RES  = WIDTH'(ERR_VAL);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic               add_ovf, sub_ovf, mul_ovf;
    logic [WIDTH-1:0]   add_res, sub_res, mul_res;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;
    assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign add_ovf = sum[WIDTH];
    assign sub_ovf = (a < b);
    assign mul_ovf = |prod[2*WIDTH-1:WIDTH];

`ifdef CALC_ALU_SAT_EN
    assign add_res = add_ovf ? ALL_ONES : sum[WIDTH-1:0];
    assign sub_res = sub_ovf ? '0       : diff;
    assign mul_res = mul_ovf ? ALL_ONES : prod[WIDTH-1:0];
`else
    assign add_res = sum[WIDTH-1:0];
    assign sub_res = diff;
    assign mul_res = prod[WIDTH-1:0];
`endif

    // One restoring step: shift the next dividend bit (quotient MSB) into the partial remainder.
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    always_comb begin
        shifted  = {prem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs});
        prem_nxt = fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
        quo_nxt  = {quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rem    <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            quo    <= '0;
            dvs    <= '0;
            prem   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            2'd0: begin
                                result <= add_res;
                                rem    <= '0;
                                ovf    <= add_ovf;
                                err    <= 1'b0;
                                done   <= 1'b1;
                            end
                            2'd1: begin
                                result <= sub_res;
                                rem    <= '0;
                                ovf    <= sub_ovf;
                                err    <= 1'b0;
                                done   <= 1'b1;
                            end
                            2'd2: begin
                                result <= mul_res;
                                rem    <= '0;
                                ovf    <= mul_ovf;
                                err    <= 1'b0;
                                done   <= 1'b1;
                            end
                            default: begin
                                if (b == '0) begin
                                    result <= ERR_RES;
                                    rem    <= '0;
                                    ovf    <= 1'b0;
                                    err    <= 1'b1;
                                    done   <= 1'b1;
                                end else begin
                                    quo   <= a;
                                    dvs   <= b;
                                    prem  <= '0;
                                    cnt   <= CNT_LOAD;
                                    busy  <= 1'b1;
                                    state <= DIV;
                                end
                            end
                        endcase
                    end
                end
                DIV: begin
                    quo  <= quo_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt - 1'b1;
                    // The last step's outcome goes straight to the outputs alongside done.
                    if (cnt == CW'(1)) begin
                        result <= quo_nxt;
                        rem    <= prem_nxt;
                        ovf    <= 1'b0;
                        err    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_seq.sv
// tb/tb_calc_alu_seq.sv - directed and randomized checks of calc_alu_seq against an arithmetic reference model
module tb_calc_alu_seq;

    localparam int     W    = 14;
    localparam int     EV   = 9999;
    localparam longint MAXV = (64'd1 << W) - 1;
`ifdef CALC_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result, rem;
    logic         ovf, err;

    int n_cmp = 0;
    int n_bad = 0;

    calc_alu_seq #(.WIDTH(W), .ERR_VAL(EV)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .rem(rem), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int o, input longint x, input longint y,
                         output longint r, output longint m, output bit v, output bit e);
        r = 0; m = 0; v = 0; e = 0;
        case (o)
            0: begin
                r = x + y; v = (r > MAXV);
                if (v) r = SAT ? MAXV : r - (MAXV + 1);
            end
            1: begin
                v = (x < y);
                r = v ? (SAT ? 0 : x - y + MAXV + 1) : x - y;
            end
            2: begin
                r = x * y; v = (r > MAXV);
                if (v) r = SAT ? MAXV : r % (MAXV + 1);
            end
            default: begin
                if (y == 0) begin r = EV; e = 1; end
                else begin r = x / y; m = x % y; end
            end
        endcase
    endtask

    // Issue one operation; inj (1..W) pulses an add start in that busy cycle of a division.
    task automatic run(input int o, input longint x, input longint y, input int inj, input string tag);
        longint er, em;
        bit     ev, ee;
        model(o, x, y, er, em, ev, ee);
        op = 2'(o); a = W'(x); b = W'(y); start = 1'b1;
        tick;
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        if (o == 3 && y != 0) begin
            for (int k = 1; k <= W; k++) begin
                chk({tag, ".busy"}, busy, 1);
                chk({tag, ".done_early"}, done, 0);
                if (k == inj) begin start = 1'b1; op = 2'd0; a = 1; b = 1; end
                tick;
                start = 1'b0;
            end
        end
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".result"}, result, er);
        chk({tag, ".rem"}, rem, em);
        chk({tag, ".ovf"}, ovf, ev);
        chk({tag, ".err"}, err, ee);
        tick;
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".result_hold"}, result, er);
    endtask

    initial begin
        int     o, dcnt;
        longint x, y, er, em;
        bit     ev, ee;

        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        tick; tick;
        chk("rst.result", result, 0);
        chk("rst.rem", rem, 0);
        chk("rst.ovf", ovf, 0);
        chk("rst.err", err, 0);
        chk("rst.done", done, 0);
        chk("rst.busy", busy, 0);
        rst = 1'b0;

        run(0, 10000, 7000, 0, "add_ovf");
        chk("add_ovf.const", result, SAT ? 16383 : 616);
        run(1, 5, 9, 0, "sub_wrap");
        chk("sub_wrap.const", result, SAT ? 0 : 16380);
        run(1, 9, 5, 0, "sub_ok");
        chk("sub_ok.const", result, 4);
        run(2, 100, 50, 0, "mul_ok");
        chk("mul_ok.const", result, 5000);
        run(3, 9999, 7, 5, "div");
        chk("div.const_q", result, 1428);
        chk("div.const_r", rem, 3);
        run(3, 123, 0, 0, "div0");
        chk("div0.const", result, 9999);
        run(0, 1, 1, 0, "add_after_err");
        chk("add_after_err.const", result, 2);
        run(2, 100, 200, 0, "mul_ovf");
        chk("mul_ovf.const", result, SAT ? 16383 : 3616);

        // Abort a division with rst in its sixth cycle.
        op = 2'd3; a = 500; b = 3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k < 6; k++) tick;
        rst = 1'b1;
        tick;
        chk("abort.done", done, 0);
        chk("abort.busy", busy, 0);
        chk("abort.result", result, 0);
        chk("abort.rem", rem, 0);
        chk("abort.ovf", ovf, 0);
        chk("abort.err", err, 0);
        rst = 1'b0; start = 1'b1; op = 2'd0; a = 1; b = 1;
        tick;
        start = 1'b0;
        chk("post_rst.done", done, 1);
        chk("post_rst.result", result, 2);

        // rst and start together: start must be discarded.
        rst = 1'b1; start = 1'b1; op = 2'd0; a = 3; b = 4;
        tick;
        rst = 1'b0; start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < W + 3; k++) begin
            if (done) dcnt++;
            tick;
        end
        chk("rst_start.no_done", dcnt, 0);
        chk("rst_start.result", result, 0);

        // Back-to-back single-cycle operations with start held high.
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            o = $urandom_range(0, 3);
            x = $urandom_range(0, MAXV);
            y = (o == 3) ? 0 : $urandom_range(0, MAXV);
            model(o, x, y, er, em, ev, ee);
            op = 2'(o); a = W'(x); b = W'(y);
            tick;
            chk("b2b.done", done, 1);
            chk("b2b.result", result, er);
            chk("b2b.ovf", ovf, ev);
            chk("b2b.err", err, ee);
        end
        start = 1'b0;
        tick;

        for (int i = 0; i < 30; i++) begin
            o = $urandom_range(0, 3);
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, MAXV);
            y = ($urandom_range(0, 7) == 0) ? 0 :
                (($urandom_range(0, 2) == 0) ? $urandom_range(1, 127) : $urandom_range(0, MAXV));
            run(o, x, y, (o == 3) ? $urandom_range(1, W) : 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
